// File: rtl/nexys4_display_spi_master_pkg.sv
// Shared types and constants for the Nexys4 display SPI master.
// Frame layout is {CMD_WRITE, addr, data}, sent MSB first.
package nexys4_spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    LOW,
    HIGH,
    HOLD,
    GAP
  } state_t;

  localparam logic [3:0] CMD_WRITE = 4'b0001;
  localparam int FRAME_WIDTH = 16;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;

  localparam logic [3:0] REG_ENABLE     = 4'd0;
  localparam logic [3:0] REG_RADIX      = 4'd9;
  localparam logic [3:0] REG_DIGIT_BASE = 4'd1;

  function automatic logic [FRAME_WIDTH-1:0] make_frame(
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] data
  );
    return {CMD_WRITE, addr, data};
  endfunction

endpackage

// File: rtl/nexys4_display_spi_master_if.sv
// Register-write request handshake into the display SPI master.
// The master modport drives the request, the slave modport returns ready.
interface nexys4_display_spi_master_if;
  import nexys4_spi_pkg::*;

  logic              req_valid_i;
  logic              req_ready_o;
  logic [ADDR_W-1:0] req_addr_i;
  logic [DATA_W-1:0] req_data_i;

  modport master (
    output req_valid_i,
    output req_addr_i,
    output req_data_i,
    input  req_ready_o
  );

  modport slave (
    input  req_valid_i,
    input  req_addr_i,
    input  req_data_i,
    output req_ready_o
  );

endinterface

// File: rtl/nexys4_display_spi_master_timer.sv
// Restartable half-period timer: tick is high in the last of every
// CLK_DIV cycles, counted from the most recent restart.
module spi_half_period_timer #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(CLK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (restart || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/nexys4_display_spi_master.sv
// SPI master sending 16-bit register-write frames to the Nexys4 display.
// Optional MISO loopback check: define NEXYS4_SPI_MISO_CHECK_EN.
module nexys4_display_spi_master
  import nexys4_spi_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int GAP_CYCLES = 8
) (
  input  logic block_clk_i,
  input  logic rst_low_i,
  nexys4_display_spi_master_if.slave req,
  output logic busy_o,
  output logic done_o,
  output logic err_o,
  output logic spi_sclk_o,
  output logic spi_ss_o,
  output logic spi_mosi_o,
  input  logic spi_miso_i
);

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  state_t                 state, state_n;
  logic [FRAME_WIDTH-1:0] sr, sr_n;
  logic [3:0]             bit_cnt, bit_cnt_n, bit_nxt;
  logic [GW-1:0]          gap_cnt, gap_cnt_n;
  logic                   sclk_n, ss_n, mosi_n, done_n;
  logic                   accept, tick, gap_last;

  assign req.req_ready_o = (state == IDLE);
  assign accept   = req.req_valid_i && (state == IDLE);
  assign gap_last = (gap_cnt == GW'(GAP_CYCLES - 1));
  assign bit_nxt  = bit_cnt + 4'd1;

  spi_half_period_timer #(
    .CLK_DIV (CLK_DIV)
  ) u_timer (
    .clk     (block_clk_i),
    .rst_n   (rst_low_i),
    .restart (accept),
    .tick    (tick)
  );

  always_ff @(posedge block_clk_i or negedge rst_low_i) begin
    if (!rst_low_i) begin
      state      <= IDLE;
      sr         <= '0;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
      spi_sclk_o <= 1'b1;
      spi_ss_o   <= 1'b1;
      spi_mosi_o <= 1'b1;
      done_o     <= 1'b0;
      busy_o     <= 1'b0;
    end else begin
      state      <= state_n;
      sr         <= sr_n;
      bit_cnt    <= bit_cnt_n;
      gap_cnt    <= gap_cnt_n;
      spi_sclk_o <= sclk_n;
      spi_ss_o   <= ss_n;
      spi_mosi_o <= mosi_n;
      done_o     <= done_n;
      busy_o     <= (state_n != IDLE);
    end
  end

  always_comb begin
    state_n   = state;
    sr_n      = sr;
    bit_cnt_n = bit_cnt;
    gap_cnt_n = gap_cnt;
    sclk_n    = spi_sclk_o;
    ss_n      = spi_ss_o;
    mosi_n    = spi_mosi_o;
    done_n    = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_n   = SETUP;
          sr_n      = make_frame(req.req_addr_i, req.req_data_i);
          bit_cnt_n = '0;
          ss_n      = 1'b0;
          sclk_n    = 1'b1;
          mosi_n    = sr_n[FRAME_WIDTH-1];
        end
      end
      SETUP: begin
        if (tick) begin
          state_n = LOW;
          sclk_n  = 1'b0;
        end
      end
      LOW: begin
        if (tick) begin
          state_n = HIGH;
          sclk_n  = 1'b1;
        end
      end
      HIGH: begin
        if (tick) begin
          if (bit_cnt == 4'd15) begin
            state_n = HOLD;
          end else begin
            // falling edge and next data bit leave together
            state_n   = LOW;
            bit_cnt_n = bit_nxt;
            sr_n      = {sr[FRAME_WIDTH-2:0], 1'b0};
            mosi_n    = sr[FRAME_WIDTH-2];
            sclk_n    = 1'b0;
          end
        end
      end
      HOLD: begin
        if (tick) begin
          state_n   = GAP;
          ss_n      = 1'b1;
          mosi_n    = 1'b1;
          done_n    = 1'b1;
          gap_cnt_n = '0;
        end
      end
      GAP: begin
        if (gap_last) begin
          state_n = IDLE;
        end else begin
          gap_cnt_n = gap_cnt + GW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

`ifdef NEXYS4_SPI_MISO_CHECK_EN
  logic [1:0] miso_sync;
  logic       err_q;
  logic       chk;

  // slave echoes bit 1 of its edge counter; edge k ends HIGH with bit_cnt=k-1
  assign chk   = (state == HIGH) && tick && (bit_cnt != 4'd15);
  assign err_o = err_q;

  always_ff @(posedge block_clk_i or negedge rst_low_i) begin
    if (!rst_low_i) begin
      miso_sync <= '0;
      err_q     <= 1'b0;
    end else begin
      miso_sync <= {miso_sync[0], spi_miso_i};
      if (accept) begin
        err_q <= 1'b0;
      end else if (chk && (miso_sync[1] != bit_nxt[1])) begin
        err_q <= 1'b1;
      end
    end
  end
`else
  logic miso_unused;

  assign miso_unused = spi_miso_i;
  assign err_o       = 1'b0;
`endif

endmodule
